// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end with in-order buffer; optional FETCH_RDATA_BYPASS_EN
module fetch_unit #(
  parameter int DEPTH = 2
) (
  input  logic        Clock,
  input  logic        nReset,
  input  logic [31:0] PC,
  output logic        hold,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  input  logic        id_ready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic             run;
  logic [31:0]      pc_q    [DEPTH];
  logic [31:0]      instr_q [DEPTH];
  logic [DEPTH-1:0] filled_q;
  logic [PW-1:0]    alloc_ptr, fill_ptr, head_ptr;
  logic [CW-1:0]    alloc_cnt, drop_cnt;
  logic [CW-1:0]    filled_cnt, unfilled_cnt;

  logic accept, drop, fill, bypass, store, consume;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  // Issue side: request only with credit from registered counts, never in a redirect cycle
  always_comb begin
    imem_addr = PC;
    imem_req  = run && !flush && (({1'b0, alloc_cnt} + {1'b0, drop_cnt}) < DEPTH_C);
    accept    = imem_req && imem_gnt;
    hold      = !accept;
  end

  // Response routing and decode-side view of the head entry
  always_comb begin
    drop = imem_rvalid && (drop_cnt != '0);
    fill = imem_rvalid && (drop_cnt == '0);
`ifdef FETCH_RDATA_BYPASS_EN
    // Responding entry is the head and nothing filled sits ahead of it
    bypass = fill && (fill_ptr == head_ptr) && !filled_q[head_ptr];
`else
    bypass = 1'b0;
`endif
    id_valid = ((alloc_cnt != '0) && filled_q[head_ptr]) || bypass;
    id_instr = bypass ? imem_rdata : instr_q[head_ptr];
    id_pc    = pc_q[head_ptr];
    consume  = id_valid && id_ready;
    // A bypassed word taken by decode this cycle never lands in the buffer
    store    = fill && !(bypass && id_ready);
  end

  // Number of allocated entries still waiting for their response
  always_comb begin
    filled_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      filled_cnt = filled_cnt + CW'(filled_q[i]);
    end
    unfilled_cnt = alloc_cnt - filled_cnt;
  end

  // Buffer, pointers and counters; a redirect converts pending responses into drops
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      run       <= 1'b0;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      alloc_cnt <= '0;
      drop_cnt  <= '0;
      filled_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
    end else begin
      run <= 1'b1;
      if (flush) begin
        alloc_ptr <= '0;
        fill_ptr  <= '0;
        head_ptr  <= '0;
        alloc_cnt <= '0;
        filled_q  <= '0;
        // Any response this cycle belongs to the old stream and uses up one drop
        drop_cnt  <= drop_cnt + unfilled_cnt - CW'(imem_rvalid);
      end else begin
        if (accept) begin
          pc_q[alloc_ptr] <= PC;
          alloc_ptr       <= ptr_inc(alloc_ptr);
        end
        if (fill) begin
          fill_ptr <= ptr_inc(fill_ptr);
        end
        if (store) begin
          instr_q[fill_ptr]  <= imem_rdata;
          filled_q[fill_ptr] <= 1'b1;
        end
        if (consume) begin
          filled_q[head_ptr] <= 1'b0;
          head_ptr           <= ptr_inc(head_ptr);
        end
        alloc_cnt <= alloc_cnt + CW'(accept) - CW'(consume);
        drop_cnt  <= drop_cnt - CW'(drop);
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
`timescale 1ns/1ps
module tb_fetch_unit;

  logic        Clock = 1'b0;
  logic        nReset = 1'b0;
  logic [31:0] PC = '0;
  logic        hold;
  logic        flush = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_ready = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clock = ~Clock;

  fetch_unit #(.DEPTH(2)) dut (
    .Clock       (Clock),
    .nReset      (nReset),
    .PC          (PC),
    .hold        (hold),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_ready    (id_ready)
  );

  // Bench-side models: program counter register and in-order memory with fixed latency
  logic [31:0] pc_reg, target;
  logic        nrst, gnt_en, ready_en, flush_en;
  int          lat, cyc;
  logic [31:0] rq_addr[$];
  int          rq_due[$];
  logic [31:0] acc_q[$];
  logic [31:0] del_pc[$];
  logic [31:0] del_instr[$];
  logic        o_req, o_hold, o_valid;
  logic [31:0] o_addr, o_instr, o_pc;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    if (a == 32'h200) return 32'h00500093;
    return {a[19:0], 12'h013};
  endfunction

  // One clock cycle: drive inputs after the falling edge, sample, then advance models
  task automatic tick();
    logic        rv, acc, cons;
    logic [31:0] aaddr;
    nReset   = nrst;
    PC       = pc_reg;
    imem_gnt = gnt_en;
    id_ready = ready_en;
    flush    = flush_en;
    rv = (rq_addr.size() > 0) && (rq_due[0] <= cyc);
    imem_rvalid = rv;
    imem_rdata  = rv ? instr_of(rq_addr[0]) : 32'h0;
    #1;
    o_req = imem_req; o_hold = hold; o_addr = imem_addr;
    o_valid = id_valid; o_instr = id_instr; o_pc = id_pc;
    acc   = imem_req && imem_gnt;
    cons  = id_valid && id_ready;
    aaddr = imem_addr;
    if (cons) begin
      del_pc.push_back(id_pc);
      del_instr.push_back(id_instr);
    end
    if (acc) acc_q.push_back(aaddr);
    @(posedge Clock);
    if (rv) begin
      void'(rq_addr.pop_front());
      void'(rq_due.pop_front());
    end
    if (acc) begin
      rq_addr.push_back(aaddr);
      rq_due.push_back(cyc + lat);
    end
    if (nrst) begin
      if (flush_en) pc_reg = target;
      else if (!o_hold) pc_reg = pc_reg + 32'd4;
    end
    cyc++;
    @(negedge Clock);
  endtask

  task automatic clear_models(input logic [31:0] start);
    pc_reg = start; target = '0; cyc = 0; lat = 1;
    gnt_en = 1'b0; ready_en = 1'b0; flush_en = 1'b0;
    rq_addr.delete(); rq_due.delete();
    acc_q.delete(); del_pc.delete(); del_instr.delete();
  endtask

  task automatic do_reset(input logic [31:0] start);
    nrst = 1'b0;
    clear_models(start);
    tick();
    tick();
    nrst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    clear_models(32'h0);
    repeat (3) tick();
    n_tests++; if (o_hold !== 1'b1) begin n_fail++; $display("FAIL reset_hold: got %0b want 1", o_hold); end
    n_tests++; if (o_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0b want 0", o_req); end
    n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_id_valid: got %0b want 0", o_valid); end
    n_tests++; if (o_instr !== 32'h0) begin n_fail++; $display("FAIL reset_id_instr: got %h want 0", o_instr); end
    n_tests++; if (o_pc !== 32'h0) begin n_fail++; $display("FAIL reset_id_pc: got %h want 0", o_pc); end
    nrst = 1'b1;
    gnt_en = 1'b1;
    tick();
    n_tests++; if (o_req !== 1'b0) begin n_fail++; $display("FAIL release_req: got %0b want 0", o_req); end
    tick();
    n_tests++; if (o_req !== 1'b1) begin n_fail++; $display("FAIL first_req: got %0b want 1", o_req); end
    n_tests++; if (o_addr !== 32'h0) begin n_fail++; $display("FAIL first_addr: got %h want 0", o_addr); end
  endtask

  task automatic test_streaming();
    do_reset(32'h0);
    gnt_en = 1'b1; ready_en = 1'b1;
    for (int i = 0; i < 30 && del_pc.size() < 4; i++) tick();
    n_tests++; if (del_pc.size() < 4) begin n_fail++; $display("FAIL stream_count: got %0d want 4", del_pc.size()); end
    for (int k = 0; k < 4 && k < del_pc.size(); k++) begin
      n_tests++; if (del_pc[k] !== 32'(4 * k)) begin n_fail++; $display("FAIL stream_pc[%0d]: got %h want %h", k, del_pc[k], 32'(4 * k)); end
      n_tests++; if (del_instr[k] !== instr_of(32'(4 * k))) begin n_fail++; $display("FAIL stream_instr[%0d]: got %h want %h", k, del_instr[k], instr_of(32'(4 * k))); end
    end
  endtask

  task automatic test_backpressure();
    do_reset(32'h0);
    gnt_en = 1'b1; ready_en = 1'b0;
    repeat (8) tick();
    n_tests++; if (acc_q.size() != 2) begin n_fail++; $display("FAIL bp_grants: got %0d want 2", acc_q.size()); end
    n_tests++; if (o_req !== 1'b0) begin n_fail++; $display("FAIL bp_req: got %0b want 0", o_req); end
    n_tests++; if (o_hold !== 1'b1) begin n_fail++; $display("FAIL bp_hold: got %0b want 1", o_hold); end
    n_tests++; if (pc_reg !== 32'h8) begin n_fail++; $display("FAIL bp_pc: got %h want 8", pc_reg); end
    acc_q.delete();
    ready_en = 1'b1;
    for (int i = 0; i < 10 && (del_pc.size() < 2 || acc_q.size() < 1); i++) tick();
    n_tests++; if (del_pc.size() < 2 || acc_q.size() < 1) begin
      n_fail++; $display("FAIL bp_resume_timeout: got %0d/%0d want 2/1", del_pc.size(), acc_q.size());
    end else begin
      if (del_pc[0] !== 32'h0) begin n_fail++; $display("FAIL bp_first_pc: got %h want 0", del_pc[0]); end
      else if (del_pc[1] !== 32'h4) begin n_fail++; $display("FAIL bp_second_pc: got %h want 4", del_pc[1]); end
      else if (acc_q[0] !== 32'h8) begin n_fail++; $display("FAIL bp_resume_addr: got %h want 8", acc_q[0]); end
    end
  endtask

  task automatic test_grant_stall();
    do_reset(32'h40);
    gnt_en = 1'b0; ready_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++; if (o_hold !== 1'b1) begin n_fail++; $display("FAIL stall_hold[%0d]: got %0b want 1", i, o_hold); end
    end
    n_tests++; if (pc_reg !== 32'h40) begin n_fail++; $display("FAIL stall_pc: got %h want 40", pc_reg); end
    gnt_en = 1'b1;
    tick();
    n_tests++; if (o_hold !== 1'b0) begin n_fail++; $display("FAIL stall_release_hold: got %0b want 0", o_hold); end
    n_tests++; if (o_addr !== 32'h40) begin n_fail++; $display("FAIL stall_release_addr: got %h want 40", o_addr); end
  endtask

  task automatic test_flush();
    do_reset(32'h10);
    gnt_en = 1'b1; ready_en = 1'b1; lat = 3;
    tick();
    tick();
    n_tests++; if (acc_q.size() != 2 || acc_q[0] !== 32'h10 || acc_q[1] !== 32'h14) begin
      n_fail++; $display("FAIL flush_setup: got %0d grants want 2 (0x10,0x14)", acc_q.size());
    end
    flush_en = 1'b1; target = 32'h100;
    tick();
    flush_en = 1'b0;
    n_tests++; if (o_req !== 1'b0) begin n_fail++; $display("FAIL flush_cycle_req: got %0b want 0", o_req); end
    for (int i = 0; i < 20 && del_pc.size() < 1; i++) tick();
    n_tests++; if (del_pc.size() < 1) begin
      n_fail++; $display("FAIL flush_timeout: got 0 deliveries want 1");
    end else begin
      if (del_pc[0] !== 32'h100) begin n_fail++; $display("FAIL flush_first_pc: got %h want 100", del_pc[0]); end
      else if (del_instr[0] !== instr_of(32'h100)) begin n_fail++; $display("FAIL flush_first_instr: got %h want %h", del_instr[0], instr_of(32'h100)); end
    end
  endtask

  task automatic test_bypass();
    do_reset(32'h200);
    gnt_en = 1'b1; ready_en = 1'b1; lat = 1;
    tick();
    tick();
`ifdef FETCH_RDATA_BYPASS_EN
    n_tests++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL byp_valid: got %0b want 1", o_valid); end
`else
    n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL byp_early_valid: got %0b want 0", o_valid); end
    tick();
    n_tests++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL byp_valid: got %0b want 1", o_valid); end
`endif
    n_tests++; if (o_instr !== 32'h00500093) begin n_fail++; $display("FAIL byp_instr: got %h want 00500093", o_instr); end
    n_tests++; if (o_pc !== 32'h200) begin n_fail++; $display("FAIL byp_pc: got %h want 200", o_pc); end
  endtask

  initial begin
    nrst = 1'b0;
    clear_models(32'h0);
    @(negedge Clock);
    test_reset();
    test_streaming();
    test_backpressure();
    test_grant_stall();
    test_flush();
    test_bypass();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
